// File: rtl/uart_fifo_bridge.sv
// Memory-mapped TX/RX byte FIFOs between the CPU bus and the buart core,
// with status, sticky error flags and a maskable level interrupt.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [1:0]  addr,
    input  logic [3:0]  we,
    input  logic        rd,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        interrupt,
    output logic        uart_wr,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_busy,
    output logic        uart_rd,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_valid
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0]         CNT_ONE = 1;

    typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_st_t;
    typedef enum logic       {RX_IDLE, RX_ACK} rx_st_t;

    tx_st_t tx_st_q, tx_st_d;
    rx_st_t rx_st_q, rx_st_d;
    logic   tx_tmo_q, tx_tmo_d;

    logic [7:0]            tx_mem_q [DEPTH];
    logic [7:0]            rx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                  tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
    logic                  rx_int_en_q, rx_int_en_d, txi_en_q, txi_en_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  irq_q, uart_wr_q, uart_rd_q;
    logic [7:0]            tx_data_q, tx_data_d;

    logic wr_en, data_wr, stat_wr, ctrl_wr, rd_en;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_idle;
    logic tx_flush, rx_flush, tx_pop, tx_push, rx_pop, rx_push, rx_push_req;
    logic tx_ovf_set, rx_ovr_set;
    logic unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign wr_en    = select & (|we);
    assign data_wr  = wr_en & (addr == 2'd0) & we[0];
    assign stat_wr  = wr_en & (addr == 2'd1) & we[0];
    assign ctrl_wr  = wr_en & (addr == 2'd2) & we[0];
    assign rd_en    = select & rd;

    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_idle  = tx_empty & (tx_st_q == TX_IDLE) & !uart_busy;

    // Flush wins over a same-cycle push; a pop in the same cycle still goes out.
    assign tx_flush    = ctrl_wr & wdata[3];
    assign rx_flush    = ctrl_wr & wdata[2];
    assign tx_pop      = (tx_st_q == TX_IDLE) & !tx_empty & !uart_busy;
    assign tx_push     = data_wr & (!tx_full | tx_pop) & !tx_flush;
    assign tx_ovf_set  = data_wr & tx_full & !tx_pop & !tx_flush;
    assign rx_pop      = rd_en & (addr == 2'd0) & !rx_empty;
    assign rx_push_req = (rx_st_q == RX_IDLE) & uart_valid;
    assign rx_push     = rx_push_req & (!rx_full | rx_pop) & !rx_flush;
    assign rx_ovr_set  = rx_push_req & rx_full & !rx_pop & !rx_flush;

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) tx_wp_d = tx_wp_q + PTR_ONE;
        if (tx_pop)  tx_rp_d = tx_rp_q + PTR_ONE;
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;
        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) rx_wp_d = rx_wp_q + PTR_ONE;
        if (rx_pop)  rx_rp_d = rx_rp_q + PTR_ONE;
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;
        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end
    end

    always_comb begin
        tx_ovf_d    = tx_ovf_set | (tx_ovf_q & !(stat_wr & wdata[5]));
        rx_ovr_d    = rx_ovr_set | (rx_ovr_q & !(stat_wr & wdata[4]));
        rx_int_en_d = ctrl_wr ? wdata[0] : rx_int_en_q;
        txi_en_d    = ctrl_wr ? wdata[1] : txi_en_q;
        tx_data_d   = tx_pop ? tx_mem_q[tx_rp_q] : tx_data_q;
        rdata_d     = rdata_q;
        if (rd_en) begin
            case (addr)
                2'd0:    rdata_d = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_mem_q[rx_rp_q]};
                2'd1:    rdata_d = {8'd0, 8'(tx_cnt_q), 8'(rx_cnt_q), 1'b0, tx_idle,
                                    tx_ovf_q, rx_ovr_q, tx_full, tx_empty, rx_full, !rx_empty};
                2'd2:    rdata_d = {30'd0, txi_en_q, rx_int_en_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // WAIT_BUSY gives buart two cycles to raise busy before giving up.
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_tmo_d = tx_tmo_q;
        case (tx_st_q)
            TX_IDLE: if (tx_pop) begin
                tx_st_d  = TX_WAIT_BUSY;
                tx_tmo_d = 1'b0;
            end
            TX_WAIT_BUSY: begin
                if (uart_busy)     tx_st_d  = TX_WAIT_DONE;
                else if (tx_tmo_q) tx_st_d  = TX_IDLE;
                else               tx_tmo_d = 1'b1;
            end
            TX_WAIT_DONE: if (!uart_busy) tx_st_d = TX_IDLE;
            default: tx_st_d = TX_IDLE;
        endcase
        rx_st_d = rx_st_q;
        case (rx_st_q)
            RX_IDLE: if (uart_valid) rx_st_d = RX_ACK;
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= wdata[7:0];
        if (rx_push) rx_mem_q[rx_wp_q] <= uart_rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st_q     <= TX_IDLE;
            rx_st_q     <= RX_IDLE;
            tx_tmo_q    <= 1'b0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tx_ovf_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            rx_int_en_q <= 1'b0;
            txi_en_q    <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            uart_wr_q   <= 1'b0;
            uart_rd_q   <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            tx_st_q     <= tx_st_d;
            rx_st_q     <= rx_st_d;
            tx_tmo_q    <= tx_tmo_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovr_q    <= rx_ovr_d;
            rx_int_en_q <= rx_int_en_d;
            txi_en_q    <= txi_en_d;
            rdata_q     <= rdata_d;
            irq_q       <= (rx_int_en_q & !rx_empty) | (txi_en_q & tx_idle);
            uart_wr_q   <= tx_pop;
            uart_rd_q   <= rx_push_req;
            tx_data_q   <= tx_data_d;
        end
    end

    assign rdata        = rdata_q;
    assign interrupt    = irq_q;
    assign uart_wr      = uart_wr_q;
    assign uart_rd      = uart_rd_q;
    assign uart_tx_data = tx_data_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: queued TX/RX bytes are compared as
// the DUT emits them on uart_wr or returns them on DATA reads.
module tb_uart_fifo_bridge;
    logic        clk = 1'b0, reset = 1'b1, select = 1'b0, rd = 1'b0;
    logic [1:0]  addr = '0;
    logic [3:0]  we = '0;
    logic [31:0] wdata = '0, rdata;
    logic        interrupt, uart_wr, uart_rd, uart_busy;
    logic [7:0]  uart_tx_data, uart_rx_data = '0;
    logic        uart_valid = 1'b0, hold_busy = 1'b0;
    int          busy_cnt = 0, busy_len = 10;
    int          checks = 0, failures = 0, wr_pulses = 0, rd_pulses = 0;
    logic [7:0]  tx_q[$], rx_q[$];
    logic [7:0]  mon_b;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .select(select), .addr(addr), .we(we), .rd(rd),
        .wdata(wdata), .rdata(rdata), .interrupt(interrupt), .uart_wr(uart_wr),
        .uart_tx_data(uart_tx_data), .uart_busy(uart_busy), .uart_rd(uart_rd),
        .uart_rx_data(uart_rx_data), .uart_valid(uart_valid)
    );

    always #5 clk = ~clk;

    // Simple buart transmitter: busy for busy_len cycles after each write pulse.
    assign uart_busy = hold_busy | (busy_cnt != 0);
    always @(posedge clk) begin
        if (reset)              busy_cnt <= 0;
        else if (uart_wr)       busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (uart_wr) begin
                wr_pulses++;
                if (tx_q.size() == 0) chk("tx_unexpected_wr", 32'd1, 32'd0);
                else begin
                    mon_b = tx_q.pop_front();
                    chk("tx_byte", {24'd0, uart_tx_data}, {24'd0, mon_b});
                    chk("tx_busy_at_wr", {31'd0, uart_busy}, 32'd0);
                end
            end
            if (uart_rd) rd_pulses++;
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk); select = 1'b1; addr = a; we = 4'hF; wdata = d;
        @(negedge clk); select = 1'b0; we = 4'h0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk); select = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk); select = 1'b0; rd = 1'b0; d = rdata;
    endtask

    task automatic status_chk(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(2'd1, d);
        chk(tag, d, exp);
    endtask

    task automatic tx_put(input logic [7:0] b);
        if (tx_q.size() < 16) tx_q.push_back(b);
        bus_wr(2'd0, {24'd0, b});
    endtask

    task automatic rx_read_chk();
        logic [31:0] d, exp;
        exp = (rx_q.size() != 0) ? {23'd0, 1'b1, rx_q.pop_front()} : 32'd0;
        bus_rd(2'd0, d);
        chk("rx_data", d, exp);
    endtask

    task automatic rx_inject(input logic [7:0] b);
        bit seen = 0;
        @(negedge clk); uart_valid = 1'b1; uart_rx_data = b;
        if (rx_q.size() < 16) rx_q.push_back(b);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (uart_rd) seen = 1;
        end
        if (!seen) chk("rx_ack_timeout", 32'd0, 32'd1);
        uart_valid = 1'b0;
    endtask

    task automatic wait_tx_drain();
        int n = 0;
        while (tx_q.size() != 0 && n < 600) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        while (uart_busy && n < 600) begin @(negedge clk); n++; end
        if (n >= 600) chk("tx_drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, exp;
        int base;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", {31'd0, interrupt}, 32'd0);
        chk("rst_wr", {31'd0, uart_wr}, 32'd0);
        chk("rst_rd", {31'd0, uart_rd}, 32'd0);
        reset = 1'b0;
        status_chk("rst_status", 32'h0000_0044);
        chk("rst_irq_after", {31'd0, interrupt}, 32'd0);
        chk("rst_no_pulses", wr_pulses + rd_pulses, 32'd0);

        // Three bytes drained by the busy model
        tx_put(8'h41); tx_put(8'h42); tx_put(8'h43);
        wait_tx_drain();
        chk("tx_pulse_count", wr_pulses, 32'd3);
        status_chk("tx_idle_back", 32'h0000_0044);

        // Fill TX with buart held busy, overflow, W1C, then flush
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) tx_put(8'h60 + 8'(i));
        status_chk("tx_full_ovf", 32'h0010_0028);
        bus_wr(2'd1, 32'h20);
        status_chk("tx_ovf_w1c", 32'h0010_0008);
        bus_wr(2'd2, 32'h8);
        tx_q.delete();
        status_chk("tx_flushed", 32'h0000_0004);
        hold_busy = 1'b0;
        repeat (5) @(negedge clk);
        status_chk("tx_flush_idle", 32'h0000_0044);
        chk("tx_no_wr_after_flush", wr_pulses, 32'd3);

        // Single RX byte with interrupt enabled
        bus_wr(2'd2, 32'h1);
        base = rd_pulses;
        rx_inject(8'h55);
        repeat (2) @(negedge clk);
        chk("rx_one_ack", rd_pulses - base, 32'd1);
        chk("rx_irq_set", {31'd0, interrupt}, 32'd1);
        status_chk("rx_one_status", 32'h0000_0145);
        rx_read_chk();
        repeat (2) @(negedge clk);
        chk("rx_irq_clear", {31'd0, interrupt}, 32'd0);
        rx_read_chk();

        // Overrun, then coincident pop and push on a full FIFO
        for (int i = 0; i < 17; i++) rx_inject(8'h80 + 8'(i));
        status_chk("rx_overrun", 32'h0000_1057);
        bus_wr(2'd1, 32'h10);
        status_chk("rx_ovr_w1c", 32'h0000_1047);
        @(negedge clk);
        uart_valid = 1'b1; uart_rx_data = 8'hA5;
        select = 1'b1; rd = 1'b1; addr = 2'd0;
        exp = {23'd0, 1'b1, rx_q.pop_front()};
        rx_q.push_back(8'hA5);
        @(negedge clk);
        select = 1'b0; rd = 1'b0; uart_valid = 1'b0;
        chk("coinc_data", rdata, exp);
        chk("coinc_ack", {31'd0, uart_rd}, 32'd1);
        status_chk("coinc_status", 32'h0000_1047);
        for (int i = 0; i < 17; i++) rx_read_chk();
        status_chk("rx_drained", 32'h0000_0044);
        bus_rd(2'd2, d);
        chk("ctrl_read", d, 32'h1);

        // TX-idle interrupt source
        bus_wr(2'd2, 32'h2);
        repeat (2) @(negedge clk);
        chk("txi_irq", {31'd0, interrupt}, 32'd1);
        bus_rd(2'd3, d);
        chk("reserved_read", d, 32'd0);

        // Reset while a byte is in flight and five more are queued
        bus_wr(2'd2, 32'h0);
        busy_len = 40;
        base = wr_pulses;
        for (int i = 0; i < 6; i++) tx_put(8'hC0 + 8'(i));
        repeat (2) @(negedge clk);
        chk("midtx_one_sent", wr_pulses - base, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tx_q.delete();
        chk("midtx_rst_wr", {31'd0, uart_wr}, 32'd0);
        chk("midtx_rst_rdata", rdata, 32'd0);
        status_chk("midtx_status", 32'h0000_0044);
        repeat (30) @(negedge clk);
        chk("midtx_no_wr", wr_pulses - base, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
Memory-mapped buffering stage between the CPU bus decode in the top level and the buart core. Replaces direct single-byte UART access with a TX FIFO drained autonomously into buart and an RX FIFO filled from buart. Provides a status word, sticky error flags and a maskable level interrupt for OR-ing into the CPU interrupt line.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (16 bytes each); legal range 2..7.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
select  in  1  bus decode hit for this block's 16-byte window.
addr  in  2  word address within window (mem_addr[3:2]).
we  in  4  byte write mask from CPU.
rd  in  1  CPU read strobe.
wdata  in  32  CPU write data.
rdata  out  32  registered read data.
interrupt  out  1  level interrupt request.
uart_wr  out  1  one-cycle write pulse to buart.
uart_tx_data  out  8  byte to transmit.
uart_busy  in  1  buart transmitter busy.
uart_rd  out  1  one-cycle acknowledge pulse to buart receiver.
uart_rx_data  in  8  received byte from buart.
uart_valid  in  1  buart holds a received byte.

Behaviour:
- Reset: FIFOs empty, counts 0, sticky flags 0, enables 0. rdata=0, uart_wr=0, uart_rd=0, uart_tx_data=0, interrupt=0. Both FSMs idle. Reset mid-transfer abandons all FIFO contents immediately.
- Register map. A write is any we!=0 with select.
  - addr0 DATA: write with we[0] pushes wdata[7:0] to TX FIFO. If TX is full, the byte is dropped and tx_overflow is set. Read pops RX head when non-empty; returns {23'b0, rx_nonempty_before_pop, head_byte}. A read when empty returns 0 and pops nothing.
  - addr1 STATUS: read returns [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_overrun, [5] tx_overflow, [6] tx_idle, [15:8] rx_count, [23:16] tx_count, others 0. Write: 1 in bit4/bit5 clears that sticky flag (W1C).
  - addr2 CTRL: [0] rx_int_en, [1] tx_idle_int_en (both R/W). [2] flush RX and [3] flush TX are write-only one-shot actions and read as 0.
  - addr3: reserved; reads 0, writes ignored.
- Read timing: on a clock edge with select & rd, rdata loads the addressed value and any DATA pop takes effect on the same edge. rdata is valid the cycle after rd and holds until the next selected read.
- tx_idle = TX FIFO empty & TX FSM in IDLE & !uart_busy.
- interrupt is registered: (rx_int_en & rx_nonempty) | (tx_idle_int_en & tx_idle).
- TX FSM:
  - IDLE: if TX non-empty and !uart_busy, drive uart_tx_data=head, pulse uart_wr for 1 cycle, pop, go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when uart_busy=1. If busy is not seen within 2 cycles, return to IDLE.
  - WAIT_DONE: go to IDLE when uart_busy=0.
- RX FSM:
  - IDLE: on uart_valid, push uart_rx_data. If RX is full, discard the byte and set rx_overrun. In both cases pulse uart_rd for 1 cycle and go to ACK.
  - ACK: one hold-off cycle so uart_valid can drop, then return to IDLE.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged. A pop from a full FIFO plus a push on the same edge is legal and does not flag overflow.
- Flush precedence:
  - Flush beats a same-cycle push; the pushed byte is lost and no flag is set.
  - A TX flush does not abort a byte already handed to buart.
  - A flush does not clear sticky flags.
- Pointers wrap modulo 2^DEPTH_LOG2. Counts are DEPTH_LOG2+1 bits, zero-extended in STATUS.
- Sticky flag set and W1C on the same cycle: set wins.

Test Plan:
- Reset, then read STATUS -> 0x00000044 (tx_empty, tx_idle); interrupt=0; uart_wr/uart_rd never pulse.
- Write 0x41,0x42,0x43 to DATA with uart_busy modelled at 10 cycles/byte -> exactly three uart_wr pulses carrying 0x41,0x42,0x43 in order, each only after busy falls; tx_idle returns to 1.
- Hold uart_busy=1, write 17 bytes -> tx_count=16, tx_full=1, tx_overflow=1. Write STATUS 0x20 -> tx_overflow=0 and tx_count still 16.
- Present 0x55 on uart_valid with CTRL=0x1 -> one uart_rd pulse, rx_count=1, interrupt=1. DATA read -> 0x155; then interrupt=0 and the next DATA read -> 0x000.
- Inject 17 bytes with no CPU reads -> rx_overrun=1 and 16 bytes retained (first 16). In the cycle a DATA pop coincides with a new byte, the count stays 16 and no further overrun is flagged.
- Assert reset while TX FSM is in WAIT_DONE with 5 bytes queued -> next cycle counts=0 and FSM IDLE. No uart_wr pulse occurs after reset releases while the FIFO stays empty.
